// File: rtl/control_unit_pkg.sv
// control_unit_pkg: instruction, control-word and state encodings shared by the
// control unit, the datapath and benches.
package control_unit_pkg;
    localparam logic [3:0] FS_MOVA = 4'b0000, FS_INC = 4'b0001, FS_ADD = 4'b0010,
                           FS_SUB = 4'b0101, FS_DEC = 4'b0110, FS_AND = 4'b1000,
                           FS_OR = 4'b1001, FS_XOR = 4'b1010, FS_NOT = 4'b1011,
                           FS_MOVB = 4'b1100, FS_SHR = 4'b1101, FS_SHL = 4'b1110;
    typedef enum logic [2:0] {
        CLS_ALU = 3'b000, CLS_LD = 3'b001, CLS_ST = 3'b010, CLS_HLT = 3'b011,
        CLS_IMM = 3'b100, CLS_NOP = 3'b101, CLS_BR = 3'b110, CLS_JMP = 3'b111
    } cls_t;
    typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_HALT} state_t;
    localparam int DA_POS = 13, AA_POS = 10, BA_POS = 7, MB_POS = 6,
                   FS_POS = 2, MD_POS = 1, RW_POS = 0;
    typedef struct packed {
        logic [2:0] da;
        logic [2:0] aa;
        logic [2:0] ba;
        logic       mb;
        logic [3:0] fs;
        logic       md;
        logic       rw;
    } ctrwrd_t;
    function automatic logic [15:0] sext6(input logic [5:0] v);
        return {{10{v[5]}}, v};
    endfunction
endpackage

// File: rtl/control_decode.sv
// control_decode: combinational IR to control-word decode plus branch/jump/halt
// qualifiers for the sequencer.
module control_decode
    import control_unit_pkg::*;
(
    input  logic [15:0] ir,
    output ctrwrd_t     cw,
    output logic [15:0] cin,
    output logic        mw,
    output logic        halt,
    output logic        brz,
    output logic        brn,
    output logic        jmp
);
    cls_t       cls;
    logic [3:0] fs;
    logic [2:0] dr, sa, sb;
    assign cls = cls_t'(ir[15:13]);
    assign {fs, dr, sa, sb} = ir[12:0];
    always_comb begin
        cw   = '0;
        cin  = '0;
        mw   = 1'b0;
        halt = 1'b0;
        brz  = 1'b0;
        brn  = 1'b0;
        jmp  = 1'b0;
        case (cls)
            CLS_ALU, CLS_IMM: begin
                cw.da = dr;
                cw.aa = sa;
                cw.ba = sb;
                cw.mb = cls == CLS_IMM;
                cw.fs = fs;
                cw.rw = 1'b1;
                cin   = cls == CLS_IMM ? {13'd0, sb} : 16'd0;
            end
            CLS_LD: begin
                cw.da = dr;
                cw.aa = sa;
                cw.md = 1'b1;
                cw.rw = 1'b1;
            end
            CLS_ST: begin
                cw.aa = sa;
                cw.ba = sb;
                mw    = 1'b1;
            end
            CLS_BR: begin
                brz   = fs == FS_MOVA;
                brn   = fs == FS_INC;
                cw.aa = (fs == FS_MOVA || fs == FS_INC) ? sa : 3'd0;
            end
            CLS_JMP: begin
                cw.aa = sa;
                jmp   = 1'b1;
            end
            CLS_HLT: halt = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: rtl/control_unit.sv
// control_unit: FETCH/DECODE/EXEC/HALT sequencer holding PC, IR and state;
// all outputs are registered and non-zero only in their owning state.
module control_unit
    import control_unit_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] Instr,
    input  logic        IACK,
    output logic        IREQ,
    output logic [15:0] Iaddr,
    input  logic [15:0] Adrin,
    input  logic        V,
    input  logic        C,
    input  logic        N,
    input  logic        Z,
    output logic [15:0] CTRWRD,
    output logic [15:0] Cin,
    output logic        MW,
    output logic        HALTED
);
    state_t      state;
    logic [15:0] pc, ir, cin;
    ctrwrd_t     cw;
    logic        mw, halt, brz, brn, jmp;
    logic        unused_flags;
    assign unused_flags = V ^ C;
    assign Iaddr = pc;
    control_decode decode (
        .ir(ir), .cw(cw), .cin(cin), .mw(mw),
        .halt(halt), .brz(brz), .brn(brn), .jmp(jmp)
    );
    // IREQ comes up one cycle after reset release, so a fetch is only accepted once requested
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= S_FETCH;
            pc     <= '0;
            ir     <= '0;
            IREQ   <= 1'b0;
            CTRWRD <= '0;
            Cin    <= '0;
            MW     <= 1'b0;
            HALTED <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (IREQ && IACK) begin
                        ir    <= Instr;
                        pc    <= pc + 16'd1;
                        IREQ  <= 1'b0;
                        state <= S_DECODE;
                    end else begin
                        IREQ <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (halt) begin
                        state  <= S_HALT;
                        HALTED <= 1'b1;
                    end else begin
                        state  <= S_EXEC;
                        CTRWRD <= cw;
                        Cin    <= cin;
                        MW     <= mw;
                    end
                end
                S_EXEC: begin
                    state  <= S_FETCH;
                    IREQ   <= 1'b1;
                    CTRWRD <= '0;
                    Cin    <= '0;
                    MW     <= 1'b0;
                    if (jmp)
                        pc <= Adrin;
                    else if ((brz && Z) || (brn && N))
                        pc <= pc + sext6({ir[8:6], ir[2:0]});
                end
                S_HALT: ;
            endcase
        end
    end
endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port CLK, input, 1, single system clock; all state updates on rising edge.
REQ-002 SHALL have port RESET, input, 1, synchronous active-high reset.
REQ-003 SHALL have port Instr, input, 16, instruction word from instruction memory; valid only when IACK=1.
REQ-004 SHALL have port IACK, input, 1, instruction memory acknowledge.
REQ-005 SHALL have port IREQ, output, 1, instruction fetch request.
REQ-006 SHALL have port Iaddr, output, 16, fetch address (current PC).
REQ-007 SHALL have port Adrin, input, 16, datapath address output (R[SA]), used by JMP.
REQ-008 SHALL have ports V, C, N, Z, input, 1 each, datapath status flags, combinational from the current CTRWRD.
REQ-009 SHALL have port CTRWRD, output, 16, datapath control word: DA[15:13], AA[12:10], BA[9:7], MB[6], FS[5:2], MD[1], RW[0].
REQ-010 SHALL have port Cin, output, 16, constant operand to datapath.
REQ-011 SHALL have port MW, output, 1, data memory write enable.
REQ-012 SHALL have port HALTED, output, 1, high while in HALT state.

Function
REQ-013 Instruction format SHALL be class[15:13], FS[12:9], DR[8:6], SA[5:3], SB[2:0].
REQ-014 FS codes SHALL be: 0000 MOVA, 0001 INC, 0010 ADD, 0101 SUB, 0110 DEC, 1000 AND, 1001 OR, 1010 XOR, 1011 NOT, 1100 MOVB, 1101 SHR, 1110 SHL.
REQ-015 States SHALL be FETCH, DECODE, EXEC, HALT; RESET forces FETCH.
REQ-016 FETCH: IREQ=1, Iaddr=PC; on IACK=1 capture Instr into IR, PC<=PC+1 (mod 2^16), go to DECODE; else remain in FETCH.
REQ-017 DECODE: one cycle, IREQ=0, CTRWRD=0; go to EXEC, or to HALT if class=011.
REQ-018 EXEC: one cycle, drive decoded CTRWRD/Cin/MW, go to FETCH; minimum instruction latency 3 cycles.
REQ-019 CTRWRD, Cin and MW SHALL be 0 in every state other than EXEC (RW=0, no register write).
REQ-020 Class 000 (register ALU): DA=DR, AA=SA, BA=SB, MB=0, FS=IR FS, MD=0, RW=1.
REQ-021 Class 100 (immediate ALU): as 000 but MB=1, Cin = zero-extended SB.
REQ-022 Class 001 (LD): DA=DR, AA=SA, FS=MOVA, MD=1, RW=1.
REQ-023 Class 010 (ST): AA=SA, BA=SB, FS=MOVA, RW=0, MW=1 for the single EXEC cycle.
REQ-024 Class 110 (branch): AA=SA, FS=MOVA, RW=0; IR FS=0000 is BRZ (taken if Z=1), FS=0001 is BRN (taken if N=1); flags sampled in EXEC; taken -> PC <= PC + sign-extended 6-bit {DR,SB}, where PC already holds branch address+1; wrap mod 2^16.
REQ-025 Class 111 (JMP): AA=SA, FS=MOVA, RW=0; PC <= Adrin at end of EXEC.
REQ-026 Class 101 and unlisted branch FS values SHALL execute as NOP (CTRWRD=0, PC unchanged beyond increment).
REQ-027 HALT: IREQ=0, HALTED=1, outputs 0; leave only on RESET.
REQ-028 IACK outside FETCH SHALL be ignored.

Reset
REQ-029 On RESET=1 at a rising edge: PC=0, IR=0, state=FETCH, IREQ registered low for that cycle's output, CTRWRD=0, Cin=0, MW=0, HALTED=0.
REQ-030 RESET mid-instruction (any state, including EXEC with MW or RW active) SHALL abort without PC update; first fetch after release from address 0.
REQ-031 RESET SHALL take priority over IACK and all state transitions in the same cycle.

Structure
REQ-032 A shared package SHALL hold FS codes, class codes, state encoding and CTRWRD field bit positions, for reuse by datapath and benches.
REQ-033 Combinational IR-to-control-word decode SHALL be a sub-module control_decode; PC, IR and state registers stay in control_unit.

Verification
REQ-034 RESET then Instr=16'h0453 (ADD R1,R2,R3) with IACK=1 in cycle 1 -> EXEC cycle CTRWRD=16'h2989, Iaddr then 16'h0001.
REQ-035 Immediate 16'h8246 (INC-class imm DR=1,SA=0,SB=6) -> EXEC Cin=16'h0006, MB=1, RW=1.
REQ-036 BRZ with Z=1, offset {DR,SB}=6'b111110 at address 16'h0010 -> next Iaddr 16'h000F; with Z=0 -> 16'h0011.
REQ-037 IACK held 0 for 5 cycles in FETCH -> IREQ stays 1, Iaddr stable, CTRWRD=0 throughout.
REQ-038 ST executed, then RESET asserted during following EXEC of a register ALU op -> RW and MW 0 next cycle, next Iaddr 16'h0000.
REQ-039 Instr class 011 -> HALTED=1 after DECODE, IREQ=0 indefinitely until RESET.
